regfile_scoreboard: RTL

Parametrised register file with an integrated write-pending scoreboard and writeback bypass. It is the next-generation replacement for the decode-stage register bank of the SIMPLE pipeline. It accepts one instruction issue per cycle with up to two source reads and one destination reservation. Issue stalls while a source has an outstanding write, and source operands are returned registered one cycle after acceptance.

---
 rtl/regfile_scoreboard.sv | 117 +++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Register file with a per-register outstanding-write scoreboard and a
//   writeback-to-issue bypass. Up to one issue is accepted per cycle. An issue
//   reads up to two sources and may reserve one destination. Source operands
//   come back registered one cycle after the issue is accepted.
// Ports
//   clock, reset_n       : clock and asynchronous active-low reset
//   issue_*              : issue request; issue_ready is combinational
//   wb_en/addr/data      : writeback, which retires one pending write
//   rd_valid, rd_*_data  : registered operands of the previous accepted issue
//   dbg_sel / dbg_data   : combinational architectural register peek (no bypass)
//   wb_err               : sticky flag for a writeback to a register with no pending write
module regfile_scoreboard #(
  parameter int WIDTH   = 16,
  parameter int NREG    = 8,
  parameter int AW      = $clog2(NREG),
  parameter int PEND_W  = 2,
  parameter int ZERO_R0 = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic             issue_use_a,
  input  logic             issue_use_b,
  input  logic [AW-1:0]    issue_src_a,
  input  logic [AW-1:0]    issue_src_b,
  input  logic             issue_dst_en,
  input  logic [AW-1:0]    issue_dst,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_a_data,
  output logic [WIDTH-1:0] rd_b_data,
  input  logic [AW-1:0]    dbg_sel,
  output logic [WIDTH-1:0] dbg_data,
  output logic             wb_err
);

  localparam bit              Z        = (ZERO_R0 != 0);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [NREG-1:0][WIDTH-1:0]  reg_q, reg_d;
  logic [NREG-1:0][PEND_W-1:0] pend_q, pend_d;
  logic [WIDTH-1:0]            rd_a_data_q, rd_a_data_d, rd_b_data_q, rd_b_data_d;
  logic                        rd_valid_q, rd_valid_d, wb_err_q, wb_err_d;

  logic [WIDTH-1:0]            rd_a_val, rd_b_val;
  logic                        haz_a, haz_b, haz_dst, accept;
  logic [NREG-1:0]             wb_hit, rsv;

  always_comb begin
    // Operand select: forced zero beats bypass, bypass beats array.
    rd_a_val = reg_q[issue_src_a];
    if (wb_en && wb_addr == issue_src_a) rd_a_val = wb_data;
    if (Z && issue_src_a == '0)          rd_a_val = '0;
    rd_b_val = reg_q[issue_src_b];
    if (wb_en && wb_addr == issue_src_b) rd_b_val = wb_data;
    if (Z && issue_src_b == '0)          rd_b_val = '0;

    // A source is clear once its last pending write retires this cycle.
    haz_a = issue_use_a && (pend_q[issue_src_a] != '0) &&
            !(wb_en && wb_addr == issue_src_a && pend_q[issue_src_a] == PEND_W'(1));
    haz_b = issue_use_b && (pend_q[issue_src_b] != '0) &&
            !(wb_en && wb_addr == issue_src_b && pend_q[issue_src_b] == PEND_W'(1));
    // A full counter frees one slot when a writeback to it lands this cycle.
    haz_dst = issue_dst_en && (pend_q[issue_dst] == PEND_MAX) &&
              !(wb_en && wb_addr == issue_dst);

    issue_ready = !haz_a && !haz_b && !haz_dst;
    accept      = issue_valid && issue_ready;

    for (int i = 0; i < NREG; i++) begin
      wb_hit[i] = wb_en && (wb_addr == AW'(i));
      rsv[i]    = accept && issue_dst_en && (issue_dst == AW'(i)) && !(Z && i == 0);
      reg_d[i]  = reg_q[i];
      if (wb_hit[i] && !(Z && i == 0)) reg_d[i] = wb_data;
      // Reserve and retire on the same register cancel out.
      pend_d[i] = pend_q[i];
      if (rsv[i] && !wb_hit[i])
        pend_d[i] = pend_q[i] + PEND_W'(1);
      else if (!rsv[i] && wb_hit[i] && pend_q[i] != '0)
        pend_d[i] = pend_q[i] - PEND_W'(1);
    end

    wb_err_d    = wb_err_q || (wb_en && pend_q[wb_addr] == '0);
    rd_valid_d  = accept;
    rd_a_data_d = accept ? rd_a_val : rd_a_data_q;
    rd_b_data_d = accept ? rd_b_val : rd_b_data_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      reg_q       <= '0;
      pend_q      <= '0;
      rd_a_data_q <= '0;
      rd_b_data_q <= '0;
      rd_valid_q  <= 1'b0;
      wb_err_q    <= 1'b0;
    end else begin
      reg_q       <= reg_d;
      pend_q      <= pend_d;
      rd_a_data_q <= rd_a_data_d;
      rd_b_data_q <= rd_b_data_d;
      rd_valid_q  <= rd_valid_d;
      wb_err_q    <= wb_err_d;
    end
  end

  assign rd_a_data = rd_a_data_q;
  assign rd_b_data = rd_b_data_q;
  assign rd_valid  = rd_valid_q;
  assign wb_err    = wb_err_q;
  assign dbg_data  = reg_q[dbg_sel];

endmodule
